inst_fetch: RTL and testbench

Instruction fetch unit: initiator side of the mem_ctrl instruction-fetch interface. It owns the fetch PC, issues one 32-bit fetch at a time to mem_ctrl, and buffers returned instructions with their PCs in a small queue for the decoder. It handles redirects (jump/branch) by flushing the queue and draining any in-flight fetch. The block sits between mem_ctrl and the decode stage.

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_fetch_queue.sv | 54 +++++
 rtl/inst_fetch.sv | 107 ++++++++++
 tb/tb_inst_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package inst_fetch_pkg;

    localparam int   ADDR_W = 32;
    localparam logic True   = 1'b1;
    localparam logic False  = 1'b0;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_BUSY = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       inst;
    } iq_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} pairs; flush beats push and pop.
module inst_queue
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  iq_entry_t              i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_valid,
    output iq_entry_t              o_head
);

    localparam int PTR_W = $clog2(DEPTH);

    iq_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the empty-masked head below gives zeros after reset.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding fetch to mem_ctrl, results queued for decode.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              inst_IF_req,
    output logic [ADDR_W-1:0] inst_IF_addr,
    input  logic              inst_IF_flag,
    input  logic [31:0]       inst_IF,
    output logic              iq_valid,
    output logic [31:0]       iq_inst,
    output logic [ADDR_W-1:0] iq_pc,
    input  logic              iq_ready,
    input  logic              jump_flag,
    input  logic [ADDR_W-1:0] jump_pc
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    if_state_e          r_state;
    if_state_e          w_next_state;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_first;
    logic               w_flag_ok;
    logic               w_room;
    logic               w_push;
    logic               w_q_push;
    logic               w_q_pop;
    logic               w_q_flush;
    logic [CNT_W-1:0]   w_count;
    iq_entry_t          w_head;
    iq_entry_t          w_push_data;

    // The first cycle of a transaction may still see the previous transaction's flag.
    assign w_flag_ok = inst_IF_flag && !r_first;
    assign w_room    = (w_count < CNT_W'(QUEUE_DEPTH));

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        w_next_state = r_state;
        w_push       = False;
        case (r_state)
            IF_IDLE: begin
                if (!jump_flag && w_room) w_next_state = IF_BUSY;
            end
            IF_BUSY: begin
                if (w_flag_ok) begin
                    w_next_state = IF_IDLE;
                    w_push       = jump_flag ? False : True;
                end else if (jump_flag) begin
                    w_next_state = IF_DROP;
                end
            end
            IF_DROP: begin
                if (w_flag_ok) w_next_state = IF_IDLE;
            end
            default: w_next_state = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IF_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_first    <= 1'b0;
        end else if (rdy) begin
            r_state <= w_next_state;
            r_first <= (r_state == IF_IDLE) && (w_next_state == IF_BUSY);
            if ((r_state == IF_IDLE) && (w_next_state == IF_BUSY)) r_addr <= r_fetch_pc;
            if (jump_flag)   r_fetch_pc <= jump_pc;
            else if (w_push) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        end
    end

    // A jump voids a same-cycle pop; a frozen pipeline accepts nothing.
    assign w_q_push    = rdy && w_push;
    assign w_q_pop     = rdy && iq_valid && iq_ready && !jump_flag;
    assign w_q_flush   = rdy && jump_flag;
    assign w_push_data = '{pc: r_fetch_pc, inst: inst_IF};

    inst_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk         (clk),
        .i_rst       (rst),
        .i_push      (w_q_push),
        .i_push_data (w_push_data),
        .i_pop       (w_q_pop),
        .i_flush     (w_q_flush),
        .o_count     (w_count),
        .o_valid     (iq_valid),
        .o_head      (w_head)
    );

    assign inst_IF_req  = (r_state != IF_IDLE);
    assign inst_IF_addr = r_addr;
    assign iq_inst      = w_head.inst;
    assign iq_pc        = w_head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a cycle-exact mem_ctrl stand-in (flag on 5th req cycle).
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        inst_IF_req;
    logic [31:0] inst_IF_addr;
    logic        inst_IF_flag;
    logic [31:0] inst_IF;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_ready;
    logic        jump_flag;
    logic [31:0] jump_pc;

    int n_checks = 0;
    int n_pass   = 0;

    inst_fetch #(
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .inst_IF_req  (inst_IF_req),
        .inst_IF_addr (inst_IF_addr),
        .inst_IF_flag (inst_IF_flag),
        .inst_IF      (inst_IF),
        .iq_valid     (iq_valid),
        .iq_inst      (iq_inst),
        .iq_pc        (iq_pc),
        .iq_ready     (iq_ready),
        .jump_flag    (jump_flag),
        .jump_pc      (jump_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // From an IDLE cycle (or reset release): enter BUSY, flag on the 5th req cycle.
    task automatic fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
        tick();
        check({tag, "_req"}, 32'(inst_IF_req), 32'd1);
        check({tag, "_addr"}, inst_IF_addr, exp_addr);
        repeat (4) tick();
        inst_IF_flag = 1'b1;
        inst_IF      = data;
        tick();
        inst_IF_flag = 1'b0;
        check({tag, "_idle"}, 32'(inst_IF_req), 32'd0);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; inst_IF_flag = 1'b0; inst_IF = '0;
        iq_ready = 1'b0; jump_flag = 1'b0; jump_pc = '0;

        // Reset state
        repeat (3) tick();
        check("rst_req",   32'(inst_IF_req), 32'd0);
        check("rst_addr",  inst_IF_addr, 32'h0);
        check("rst_valid", 32'(iq_valid), 32'd0);
        check("rst_inst",  iq_inst, 32'h0);
        check("rst_pc",    iq_pc, 32'h0);

        // First fetch after release
        rst = 1'b1;
        fetch("f0", 32'h0, 32'h0000_0013);
        check("f0_valid", 32'(iq_valid), 32'd1);
        check("f0_inst",  iq_inst, 32'h0000_0013);
        check("f0_pc",    iq_pc, 32'h0);

        // Fill the queue with iq_ready low
        fetch("f1", 32'h4, 32'hA4);
        fetch("f2", 32'h8, 32'hA8);
        fetch("f3", 32'hC, 32'hAC);
        check("full_head_pc", iq_pc, 32'h0);
        repeat (3) tick();
        check("full_no_req", 32'(inst_IF_req), 32'd0);
        iq_ready = 1'b1;
        tick();
        iq_ready = 1'b0;
        check("pop1_pc",     iq_pc, 32'h4);
        check("pop1_inst",   iq_inst, 32'hA4);
        check("pop1_no_req", 32'(inst_IF_req), 32'd0);
        tick();
        check("refill_req",  32'(inst_IF_req), 32'd1);
        check("refill_addr", inst_IF_addr, 32'h10);

        // Stale flag in the first BUSY cycle is ignored
        inst_IF_flag = 1'b1;
        inst_IF      = 32'hDEAD;
        tick();
        inst_IF_flag = 1'b0;
        check("stale_still_busy", 32'(inst_IF_req), 32'd1);
        repeat (3) tick();
        inst_IF_flag = 1'b1;
        inst_IF      = 32'hB10;
        tick();
        inst_IF_flag = 1'b0;
        check("stale_idle", 32'(inst_IF_req), 32'd0);

        // Drain: heads 4, 8, C, 10 in order
        iq_ready = 1'b1;
        check("drain0_pc", iq_pc, 32'h4);
        tick();
        check("drain1_pc", iq_pc, 32'h8);
        tick();
        check("drain2_pc", iq_pc, 32'hC);
        tick();
        check("drain3_pc",   iq_pc, 32'h10);
        check("drain3_inst", iq_inst, 32'hB10);
        tick();
        iq_ready = 1'b0;
        check("drain_empty", 32'(iq_valid), 32'd0);
        check("drain_req",   32'(inst_IF_req), 32'd1);
        check("drain_addr",  inst_IF_addr, 32'h14);

        // Reset mid-fetch
        rst = 1'b0;
        tick();
        check("midrst_req",   32'(inst_IF_req), 32'd0);
        check("midrst_addr",  inst_IF_addr, 32'h0);
        check("midrst_valid", 32'(iq_valid), 32'd0);
        rst = 1'b1;

        // Jump in the 2nd BUSY cycle of addr 8
        fetch("g0", 32'h0, 32'h11);
        fetch("g1", 32'h4, 32'h22);
        check("g_valid", 32'(iq_valid), 32'd1);
        tick();
        check("j_busy_addr", inst_IF_addr, 32'h8);
        tick();
        jump_flag = 1'b1;
        jump_pc   = 32'h100;
        tick();
        jump_flag = 1'b0;
        check("j_flushed",   32'(iq_valid), 32'd0);
        check("j_drop_req",  32'(inst_IF_req), 32'd1);
        check("j_drop_addr", inst_IF_addr, 32'h8);
        repeat (2) tick();
        inst_IF_flag = 1'b1;
        inst_IF      = 32'hBAD;
        tick();
        inst_IF_flag = 1'b0;
        check("j_dropped_valid", 32'(iq_valid), 32'd0);
        check("j_dropped_req",   32'(inst_IF_req), 32'd0);
        fetch("j_target", 32'h100, 32'hC100);
        check("j_target_pc", iq_pc, 32'h100);

        // Jump coincident with flag and pop
        tick();
        check("jc_addr", inst_IF_addr, 32'h104);
        repeat (4) tick();
        inst_IF_flag = 1'b1;
        inst_IF      = 32'hEEEE;
        jump_flag    = 1'b1;
        jump_pc      = 32'h200;
        iq_ready     = 1'b1;
        tick();
        inst_IF_flag = 1'b0;
        jump_flag    = 1'b0;
        iq_ready     = 1'b0;
        check("jc_valid", 32'(iq_valid), 32'd0);
        check("jc_req",   32'(inst_IF_req), 32'd0);
        tick();
        check("jc_next_req",  32'(inst_IF_req), 32'd1);
        check("jc_next_addr", inst_IF_addr, 32'h200);

        // rdy low for 3 cycles mid-BUSY
        tick();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("frz_req",   32'(inst_IF_req), 32'd1);
            check("frz_addr",  inst_IF_addr, 32'h200);
            check("frz_valid", 32'(iq_valid), 32'd0);
        end
        rdy = 1'b1;
        repeat (2) tick();
        check("frz_late_req", 32'(inst_IF_req), 32'd1);
        tick();
        inst_IF_flag = 1'b1;
        inst_IF      = 32'hF200;
        tick();
        inst_IF_flag = 1'b0;
        check("frz_done_req", 32'(inst_IF_req), 32'd0);
        check("frz_valid1",   32'(iq_valid), 32'd1);
        check("frz_pc",       iq_pc, 32'h200);
        check("frz_inst",     iq_inst, 32'hF200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
